// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the memory-bus arbiter: FSM states, default widths
// and a constant log2 used to size the pointer and latency counter.
package mem_bus_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Master-side bus of the arbiter: per-master request bundle in, grant/ack/read data out.
interface mem_bus_arbiter_if
    import mem_bus_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      rdata;

    modport slave (
        input  req, lock, we, addr, wdata,
        output gnt, ack, rdata
    );

    modport master (
        output req, lock, we, addr, wdata,
        input  gnt, ack, rdata
    );
endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping around.
// Returns the winner as one-hot and as an index; both are zero when nothing is requested.
module rr_pick
    import mem_bus_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [PW-1:0]   win_idx
);
    logic          found;
    logic [PW-1:0] j;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        j       = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = PW'((int'(ptr) + k) % NREQ);
            if (!found && req[j]) begin
                found     = 1'b1;
                win_oh[j] = 1'b1;
                win_idx   = j;
            end
        end
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter with lock sharing one synchronous memory port among NREQ masters.
// state | meaning: IDLE pick winner | ISSUE mem strobe | WAIT read latency | DONE ack
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int MEM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_bus_arbiter_if.slave bus,
    output logic             mem_en,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,
    output logic             busy
);
    localparam int PW = clog2(NREQ);
    localparam int CW = clog2(MEM_LAT + 1);

    state_t          state, state_nx;
    logic [NREQ-1:0] gnt_q, gnt_nx;
    logic [NREQ-1:0] ack_q, ack_nx;
    logic [DW-1:0]   rdata_q, rdata_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [PW-1:0]   ptr, ptr_nx;
    logic [PW-1:0]   lock_owner, own_nx;
    logic            lock_vld, lvld_nx;
    logic [PW-1:0]   win, win_nx;
    logic            h_we, hwe_nx;
    logic [AW-1:0]   h_addr, haddr_nx;
    logic [DW-1:0]   h_wdata, hwd_nx;

    logic [NREQ-1:0] rr_oh, owner_oh, sel_oh;
    logic [PW-1:0]   rr_idx, sel_idx;
    logic            owner_hit;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req     (bus.req),
        .ptr     (ptr),
        .win_oh  (rr_oh),
        .win_idx (rr_idx)
    );

    // A valid lock owner that is still requesting bypasses the round-robin search.
    always_comb begin
        owner_oh             = '0;
        owner_oh[lock_owner] = 1'b1;
        owner_hit            = lock_vld & bus.req[lock_owner];
        sel_idx              = owner_hit ? lock_owner : rr_idx;
        sel_oh               = owner_hit ? owner_oh : rr_oh;
    end

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt_q;
        ack_nx   = '0;
        rdata_nx = rdata_q;
        cnt_nx   = cnt;
        ptr_nx   = ptr;
        own_nx   = lock_owner;
        lvld_nx  = lock_vld;
        win_nx   = win;
        hwe_nx   = h_we;
        haddr_nx = h_addr;
        hwd_nx   = h_wdata;
        case (state)
            IDLE: begin
                if (lock_vld && !bus.req[lock_owner]) lvld_nx = 1'b0;
                if (|bus.req) begin
                    win_nx   = sel_idx;
                    gnt_nx   = sel_oh;
                    hwe_nx   = bus.we[sel_idx];
                    haddr_nx = bus.addr[int'(sel_idx) * AW +: AW];
                    hwd_nx   = bus.wdata[int'(sel_idx) * DW +: DW];
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                cnt_nx   = CW'(MEM_LAT);
                state_nx = WAIT;
            end
            WAIT: begin
                if (cnt == CW'(1)) begin
                    if (!h_we) rdata_nx = mem_rdata;
                    ack_nx   = gnt_q;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            DONE: begin
                gnt_nx   = '0;
                ptr_nx   = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                own_nx   = win;
                lvld_nx  = bus.lock[win];
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt_q      <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
            cnt        <= '0;
            ptr        <= '0;
            lock_owner <= '0;
            lock_vld   <= 1'b0;
            win        <= '0;
            h_we       <= 1'b0;
            h_addr     <= '0;
            h_wdata    <= '0;
        end else begin
            state      <= state_nx;
            gnt_q      <= gnt_nx;
            ack_q      <= ack_nx;
            rdata_q    <= rdata_nx;
            cnt        <= cnt_nx;
            ptr        <= ptr_nx;
            lock_owner <= own_nx;
            lock_vld   <= lvld_nx;
            win        <= win_nx;
            h_we       <= hwe_nx;
            h_addr     <= haddr_nx;
            h_wdata    <= hwd_nx;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
    assign mem_en    = (state == ISSUE);
    assign mem_we    = mem_en & h_we;
    assign mem_addr  = h_addr;
    assign mem_wdata = h_wdata;
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic against a
// transaction-level arbitration model; a second instance covers MEM_LAT = 3.
module tb_mem_bus_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst3_n, mem_init;

    mem_bus_arbiter_if #(.NREQ(N), .AW(8), .DW(8)) bus1 ();
    mem_bus_arbiter_if #(.NREQ(N), .AW(8), .DW(8)) bus3 ();

    logic       mem_en1, mem_we1, busy1, mem_en3, mem_we3, busy3;
    logic [7:0] mem_addr1, mem_wdata1, mem_rdata1, mem_addr3, mem_wdata3, mem_rdata3;

    mem_bus_arbiter #(.NREQ(N), .AW(8), .DW(8), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
    );

    mem_bus_arbiter #(.NREQ(N), .AW(8), .DW(8), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .bus(bus3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3)
    );

    // Memory environments: contents start as addr ^ 0xB5; read data is valid only
    // in the cycle exactly MEM_LAT after the strobe, zero otherwise.
    logic [7:0] mem1 [256];
    logic [7:0] rd1_q;
    logic [7:0] p3 [3];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int a = 0; a < 256; a++) mem1[a] <= 8'(a) ^ 8'hB5;
        end else if (mem_en1 && mem_we1) begin
            mem1[mem_addr1] <= mem_wdata1;
        end
        rd1_q <= (mem_en1 && !mem_we1) ? mem1[mem_addr1] : 8'h00;
        p3[0] <= (mem_en3 && !mem_we3) ? (mem_addr3 ^ 8'hB5) : 8'h00;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem_rdata1 = rd1_q;
    assign mem_rdata3 = p3[2];

    int         n_err = 0;
    int         n_chk = 0;
    bit         p_req [N];
    bit         p_we [N];
    bit         p_lock [N];
    logic [7:0] p_addr [N];
    logic [7:0] p_wdata [N];
    logic [7:0] ref_mem [256];
    int         m_ptr, m_own, w;
    bit         m_lvld, any, c_we;
    logic [7:0] m_rdata, c_addr, c_wdata;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive1();
        for (int i = 0; i < N; i++) begin
            bus1.req[i]           = p_req[i];
            bus1.lock[i]          = p_lock[i];
            bus1.we[i]            = p_we[i];
            bus1.addr[i*8 +: 8]   = p_addr[i];
            bus1.wdata[i*8 +: 8]  = p_wdata[i];
        end
    endtask

    task automatic clear_p();
        for (int i = 0; i < N; i++) begin
            p_req[i] = 1'b0; p_we[i] = 1'b0; p_lock[i] = 1'b0;
            p_addr[i] = 8'h00; p_wdata[i] = 8'h00;
        end
    endtask

    task automatic new_req(input int i);
        p_req[i]   = 1'b1;
        p_we[i]    = 1'($urandom_range(0, 1));
        p_addr[i]  = 8'($urandom_range(0, 255));
        p_wdata[i] = 8'($urandom_range(0, 255));
        p_lock[i]  = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; rst3_n = 1'b0; mem_init = 1'b1;
        clear_p(); drive1();
        bus3.req = '0; bus3.lock = '0; bus3.we = '0; bus3.addr = '0; bus3.wdata = '0;
        for (int a = 0; a < 256; a++) ref_mem[a] = 8'(a) ^ 8'hB5;
        repeat (3) step();
        mem_init = 1'b0;

        chk("rst_gnt", bus1.gnt, 0);
        chk("rst_ack", bus1.ack, 0);
        chk("rst_mem_en", mem_en1, 0);
        chk("rst_rdata", bus1.rdata, 0);
        chk("rst_busy", busy1, 0);
        rst_n = 1'b1; rst3_n = 1'b1;

        // single read by master 2
        p_req[2] = 1'b1; p_addr[2] = 8'h10; drive1();
        step();
        chk("rd_gnt", bus1.gnt, 4'b0100);
        chk("rd_mem_en", mem_en1, 1);
        chk("rd_mem_addr", mem_addr1, 8'h10);
        chk("rd_mem_we", mem_we1, 0);
        step();
        chk("rd_ack_early", bus1.ack, 0);
        step();
        chk("rd_ack", bus1.ack, 4'b0100);
        chk("rd_rdata", bus1.rdata, 8'hA5);
        p_req[2] = 1'b0; drive1(); step();

        // master 0 writes, master 1 reads back
        p_req[0] = 1'b1; p_we[0] = 1'b1; p_addr[0] = 8'h20; p_wdata[0] = 8'h3C; drive1();
        step();
        chk("wr_gnt", bus1.gnt, 4'b0001);
        chk("wr_mem_we", mem_we1, 1);
        chk("wr_mem_addr", mem_addr1, 8'h20);
        chk("wr_mem_wdata", mem_wdata1, 8'h3C);
        step(); step();
        chk("wr_ack", bus1.ack, 4'b0001);
        chk("wr_rdata_held", bus1.rdata, 8'hA5);
        p_req[0] = 1'b0; p_we[0] = 1'b0; drive1(); step();
        ref_mem[8'h20] = 8'h3C;
        p_req[1] = 1'b1; p_addr[1] = 8'h20; drive1();
        step();
        chk("rb_gnt", bus1.gnt, 4'b0010);
        step(); step();
        chk("rb_ack", bus1.ack, 4'b0010);
        chk("rb_rdata", bus1.rdata, 8'h3C);
        p_req[1] = 1'b0; drive1(); step();

        // round-robin with all requests held from reset
        rst_n = 1'b0; clear_p();
        for (int i = 0; i < N; i++) begin p_req[i] = 1'b1; p_addr[i] = 8'(8'h40 + i); end
        drive1(); step(); rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_gnt", bus1.gnt, 32'(1) << (k % N));
            step(); step();
            chk("rr_ack", bus1.ack, 32'(1) << (k % N));
            chk("rr_rdata", bus1.rdata, ref_mem[8'h40 + k % N]);
            step();
        end

        // lock: master 0 holds the port for three accesses while master 1 waits
        rst_n = 1'b0; clear_p();
        p_req[0] = 1'b1; p_lock[0] = 1'b1; p_addr[0] = 8'h50;
        p_req[1] = 1'b1; p_addr[1] = 8'h51;
        drive1(); step(); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("lock_gnt", bus1.gnt, 4'b0001);
            step(); step();
            chk("lock_ack", bus1.ack, 4'b0001);
            if (k == 2) begin p_lock[0] = 1'b0; drive1(); end
            step();
        end
        step();
        chk("lock_rel_gnt", bus1.gnt, 4'b0010);
        step(); step();
        chk("lock_rel_ack", bus1.ack, 4'b0010);
        clear_p(); drive1(); step();

        // random traffic against the transaction-level model
        rst_n = 1'b0; clear_p(); drive1(); step(); rst_n = 1'b1;
        m_ptr = 0; m_own = 0; m_lvld = 1'b0; m_rdata = 8'h00;
        for (int t = 0; t < 200; t++) begin
            for (int i = 0; i < N; i++)
                if (!p_req[i] && $urandom_range(0, 2) == 0) new_req(i);
            drive1();
            if (m_lvld && !p_req[m_own]) m_lvld = 1'b0;
            any = 1'b0;
            for (int i = 0; i < N; i++) any |= p_req[i];
            if (!any) begin
                step();
                chk("rnd_idle_gnt", bus1.gnt, 0);
                chk("rnd_idle_busy", busy1, 0);
                continue;
            end
            w = -1;
            if (m_lvld) w = m_own;
            else
                for (int k = 0; k < N; k++)
                    if (w < 0 && p_req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            c_we = p_we[w]; c_addr = p_addr[w]; c_wdata = p_wdata[w];
            step();
            chk("rnd_gnt", bus1.gnt, 32'(1) << w);
            chk("rnd_mem_en", mem_en1, 1);
            chk("rnd_mem_addr", mem_addr1, c_addr);
            chk("rnd_mem_we", mem_we1, c_we);
            chk("rnd_mem_wdata", mem_wdata1, c_wdata);
            bus1.addr[w*8 +: 8]  = 8'($urandom_range(0, 255));
            bus1.wdata[w*8 +: 8] = 8'($urandom_range(0, 255));
            bus1.we[w]           = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin p_req[w] = 1'b0; bus1.req[w] = 1'b0; end
            step();
            chk("rnd_wait_ack", bus1.ack, 0);
            chk("rnd_wait_mem_en", mem_en1, 0);
            step();
            if (c_we) ref_mem[c_addr] = c_wdata;
            else m_rdata = ref_mem[c_addr];
            chk("rnd_ack", bus1.ack, 32'(1) << w);
            chk("rnd_ack_gnt", bus1.gnt, 32'(1) << w);
            chk("rnd_rdata", bus1.rdata, m_rdata);
            p_req[w] = 1'b0;
            if ($urandom_range(0, 1) == 1) new_req(w);
            drive1();
            m_ptr = (w + 1) % N; m_own = w; m_lvld = p_lock[w];
            step();
        end

        // asynchronous reset in the middle of an access
        for (int i = 0; i < N; i++) new_req(i);
        drive1();
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", bus1.gnt, 0);
        chk("arst_ack", bus1.ack, 0);
        chk("arst_mem_en", mem_en1, 0);
        chk("arst_rdata", bus1.rdata, 0);
        chk("arst_busy", busy1, 0);
        step();
        chk("arst_no_ack", bus1.ack, 0);
        rst_n = 1'b1;

        // MEM_LAT = 3 instance: reset during WAIT, then normal access
        bus3.req = 4'b0100; bus3.addr[2*8 +: 8] = 8'h33;
        step();
        chk("l3_gnt", bus3.gnt, 4'b0100);
        chk("l3_mem_en", mem_en3, 1);
        step(); step();
        rst3_n = 1'b0;
        #1;
        chk("l3_rst_gnt", bus3.gnt, 0);
        chk("l3_rst_ack", bus3.ack, 0);
        chk("l3_rst_mem_en", mem_en3, 0);
        chk("l3_rst_busy", busy3, 0);
        chk("l3_rst_rdata", bus3.rdata, 0);
        bus3.req = 4'b1111; bus3.addr[0 +: 8] = 8'h44;
        step();
        chk("l3_rst_no_ack_a", bus3.ack, 0);
        step();
        chk("l3_rst_no_ack_b", bus3.ack, 0);
        rst3_n = 1'b1;
        step();
        chk("l3_post_gnt", bus3.gnt, 4'b0001);
        step(); step(); step();
        chk("l3_post_ack_early", bus3.ack, 0);
        step();
        chk("l3_post_ack", bus3.ack, 4'b0001);
        chk("l3_post_rdata", bus3.rdata, 8'hF1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 8-bit memory port (address, data, read/write) between NREQ bus masters: the 8-bit core's fetch/load/store path, a DMA engine and debug access.
- Grants are round-robin. A lock option lets a master perform consecutive accesses uninterrupted, for example an address-fetch followed by the data access.
- Each access is sequenced against a synchronous memory with fixed read latency. The block returns registered read data and a one-cycle acknowledge.

Parameters:
- NREQ, 4, number of requesting masters (2..8)
- AW, 8, address width
- DW, 8, data width
- MEM_LAT, 1, cycles from the mem_en cycle to valid mem_rdata (1..7)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-master access request, level
- lock  in  NREQ  per-master lock hint, sampled at ack
- we  in  NREQ  per-master write enable (1 = write)
- addr  in  NREQ*AW  flattened per-master address; master i uses bits [i*AW +: AW]
- wdata  in  NREQ*DW  flattened per-master write data
- gnt  out  NREQ  one-hot grant, registered
- ack  out  NREQ  one-hot completion pulse, one cycle
- rdata  out  DW  read data, valid in the ack cycle, held until the next ack
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- busy  out  1  high in any state other than IDLE

Behaviour:
Reset (asynchronous, takes effect immediately, including mid-access):
- All outputs go to 0; state goes to IDLE.
- Round-robin pointer goes to 0; lock owner is cleared.

States: IDLE, ISSUE, WAIT, DONE.

IDLE:
- If no req is set, remain in IDLE.
- Otherwise choose a winner w:
  - If the lock owner is valid and req[owner] = 1, w = owner.
  - Otherwise w is the first requester with req set, searching upward from the pointer with wrap-around.
- Latch addr[w], we[w] and wdata[w] into holding registers; go to ISSUE.

ISSUE (exactly 1 cycle):
- gnt[w] = 1.
- mem_en = 1; mem_we, mem_addr and mem_wdata driven from the latched values.
- Load the wait counter with MEM_LAT; go to WAIT.

WAIT:
- gnt[w] held; mem_en = 0.
- Decrement the counter. When it reaches 0, capture mem_rdata into rdata (writes leave rdata unchanged) and go to DONE.

DONE (1 cycle):
- ack[w] = 1, gnt[w] still 1.
- Pointer = (w+1) mod NREQ.
- If lock[w] = 1, the lock owner becomes w; otherwise the lock owner is cleared.
- Go to IDLE.

Timing:
- Request first seen in IDLE at cycle T0: gnt and mem_en rise at T1, ack at T1+MEM_LAT+1.
- Maximum throughput is one access per MEM_LAT+3 cycles.

Rules:
- Masters may change addr/we/wdata only after ack. The block ignores any change after the IDLE sample.
- If a master drops req mid-access, the access still completes and ack still pulses.
- In IDLE, if the lock owner has req = 0, the lock is released and normal round-robin applies in the same cycle.
- Lock does not move the pointer. After the lock is released, arbitration resumes from owner+1.
- Outputs are never X; gnt and ack are always zero or one-hot.

Decomposition:
- Shared package mem_bus_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, DONE);
  - default widths AW_DEF = 8 and DW_DEF = 8;
  - the function clog2 used for pointer and counter widths.
- One sub-module, rr_pick: takes req and pointer and returns a one-hot winner plus its index. It is purely combinational and parameterised by NREQ.
- The pointer, lock owner, FSM and datapath registers stay in mem_bus_arbiter.

Test Plan:
- Reset: assert rst_n = 0 mid-run with random inputs -> gnt = 0, ack = 0, mem_en = 0, rdata = 0x00 and busy = 0 in the same cycle.
- Single read, NREQ = 4, MEM_LAT = 1, memory[0x10] = 0xA5: req[2] = 1, addr = 0x10 -> gnt = 4'b0100 and mem_en = 1 with mem_addr = 0x10 at T1; ack = 4'b0100 and rdata = 0xA5 at T3.
- Write then read: master 0 writes 0x3C to address 0x20 (mem_we = 1 at T1); master 1 then reads 0x20 -> rdata = 0x3C; rdata unchanged by the write's ack.
- Round-robin: all four req held high from reset -> grant order 0, 1, 2, 3, 0, 1, with each ack 4 cycles apart.
- Lock: master 0 requests with lock = 1 while master 1 is pending -> master 0 wins 3 consecutive accesses. Master 0 then drops lock at its third ack -> the next grant goes to master 1.
- Reset mid-WAIT with MEM_LAT = 3: pull rst_n low during WAIT -> outputs clear asynchronously, no ack appears, and after release req = 4'b1111 is granted to master 0 first.
